dmem_arbiter: RTL and testbench

- Shares the single-ported data memory between two requesters: requester 0 (the CPU load/store path) and requester 1 (an auxiliary master, e.g. a debug loader or UI DMA).
- Sits between the I/O address decoder and the data-memory controller.
- Performs per-cycle arbitration, drives the memory write enable, word index and write data, and routes synchronous read data back to the requester that issued the read.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_arb_core.sv | 69 ++++++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding and arbitration modes.
// Imported by the arbitration core and the top-level datapath.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWNER_R0 = 1'b0,
    OWNER_R1 = 1'b1
  } owner_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Wide enough for the largest supported starvation limit (15).
  localparam int STARVE_W  = 4;

endpackage

// File: rtl/dmem_arbiter_arb_core.sv
// Grant logic for the two data-memory requesters.
// Holds the last-granted owner (round-robin) and the requester-1 starvation counter (fixed priority).
module arb_core
  import dmem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO   = ARB_RR,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic r0_req,
  input  logic r1_req,
  output logic r0_gnt,
  output logic r1_gnt
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  owner_e              lastGnt_q, lastGnt_d;
  logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;
  logic                tieToR1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastGnt_q   <= OWNER_R1;
      starveCnt_q <= '0;
    end else begin
      lastGnt_q   <= lastGnt_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  always_comb begin
    if (FIXED_PRIO == ARB_FIXED) begin
      tieToR1 = (starveCnt_q == LIMIT);
    end else begin
      tieToR1 = (lastGnt_q == OWNER_R0);
    end
  end

  // Grants stay low while reset is held, even with requests pending.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (reset) begin
      if (r0_req && r1_req) begin
        r0_gnt = !tieToR1;
        r1_gnt = tieToR1;
      end else begin
        r0_gnt = r0_req;
        r1_gnt = r1_req;
      end
    end
  end

  always_comb begin
    lastGnt_d   = lastGnt_q;
    starveCnt_d = '0;
    if (r0_gnt) begin
      lastGnt_d = OWNER_R0;
    end else if (r1_gnt) begin
      lastGnt_d = OWNER_R1;
    end
    if ((FIXED_PRIO == ARB_FIXED) && r1_req && !r1_gnt) begin
      starveCnt_d = (starveCnt_q == LIMIT) ? LIMIT : starveCnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU path (r0) and an auxiliary master (r1).
// Muxes the granted request onto the memory port and returns synchronous read data to its owner.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int DMEMADDRBITS = 13,
  parameter int DMEMWORDBITS = 2,
  parameter int FIXED_PRIO   = ARB_RR,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 r0_req,
  input  logic                                 r0_we,
  input  logic [DMEMADDRBITS-1:0]              r0_addr,
  input  logic [DBITS-1:0]                     r0_wdata,
  output logic                                 r0_gnt,
  output logic                                 r0_rvalid,
  output logic [DBITS-1:0]                     r0_rdata,
  input  logic                                 r1_req,
  input  logic                                 r1_we,
  input  logic [DMEMADDRBITS-1:0]              r1_addr,
  input  logic [DBITS-1:0]                     r1_wdata,
  output logic                                 r1_gnt,
  output logic                                 r1_rvalid,
  output logic [DBITS-1:0]                     r1_rdata,
  output logic                                 mem_wrtEn,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_index,
  output logic [DBITS-1:0]                     mem_dataIn,
  input  logic [DBITS-1:0]                     mem_dataOut,
  output logic                                 misalign
);

  localparam int IDXBITS = DMEMADDRBITS - DMEMWORDBITS;

  logic                    anyGnt;
  logic                    gntWe;
  logic [DMEMADDRBITS-1:0] gntAddr;
  logic [DBITS-1:0]        gntWdata;

  logic [IDXBITS-1:0]      index_q;
  logic [DBITS-1:0]        dataIn_q;
  logic                    rdPend_q, rdPend_d;
  owner_e                  rdOwner_q, rdOwner_d;
  logic [DBITS-1:0]        r0Data_q, r1Data_q;
  logic                    misalign_q, misalign_d;

  arb_core #(
    .FIXED_PRIO  (FIXED_PRIO),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uArbCore (
    .clk   (clk),
    .reset (reset),
    .r0_req(r0_req),
    .r1_req(r1_req),
    .r0_gnt(r0_gnt),
    .r1_gnt(r1_gnt)
  );

  always_comb begin
    anyGnt   = r0_gnt | r1_gnt;
    gntWe    = r0_we;
    gntAddr  = r0_addr;
    gntWdata = r0_wdata;
    if (r1_gnt) begin
      gntWe    = r1_we;
      gntAddr  = r1_addr;
      gntWdata = r1_wdata;
    end
  end

  // Index and write data hold their last granted value on idle cycles.
  always_comb begin
    mem_wrtEn  = anyGnt & gntWe;
    mem_index  = anyGnt ? gntAddr[DMEMADDRBITS-1:DMEMWORDBITS] : index_q;
    mem_dataIn = anyGnt ? gntWdata : dataIn_q;
  end

  always_comb begin
    rdPend_d   = anyGnt & !gntWe;
    rdOwner_d  = r1_gnt ? OWNER_R1 : OWNER_R0;
    misalign_d = misalign_q | (anyGnt && (gntAddr[DMEMWORDBITS-1:0] != '0));
  end

  // Read data is steered to whichever requester issued the read one cycle earlier.
  always_comb begin
    r0_rvalid = rdPend_q && (rdOwner_q == OWNER_R0);
    r1_rvalid = rdPend_q && (rdOwner_q == OWNER_R1);
    r0_rdata  = r0_rvalid ? mem_dataOut : r0Data_q;
    r1_rdata  = r1_rvalid ? mem_dataOut : r1Data_q;
    misalign  = misalign_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q    <= '0;
      dataIn_q   <= '0;
      rdPend_q   <= 1'b0;
      rdOwner_q  <= OWNER_R0;
      r0Data_q   <= '0;
      r1Data_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      index_q    <= mem_index;
      dataIn_q   <= mem_dataIn;
      rdPend_q   <= rdPend_d;
      rdOwner_q  <= rdOwner_d;
      r0Data_q   <= r0_rdata;
      r1Data_q   <= r1_rdata;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each with its own memory,
// checked cycle by cycle against a behavioural model of grants, memory contents and read returns.
module tb_dmem_arbiter;

  localparam int DB  = 32;
  localparam int AB  = 13;
  localparam int WB  = 2;
  localparam int IB  = AB - WB;
  localparam int LIM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          memClear;
  int            sel;
  logic          r0Req, r0We, r1Req, r1We;
  logic [AB-1:0] r0Addr, r1Addr;
  logic [DB-1:0] r0Wdata, r1Wdata;

  wire          r0Gnt [2];
  wire          r1Gnt [2];
  wire          r0Rv  [2];
  wire          r1Rv  [2];
  wire          memWe [2];
  wire          misal [2];
  wire [DB-1:0] r0Rd  [2];
  wire [DB-1:0] r1Rd  [2];
  wire [DB-1:0] memDin[2];
  wire [IB-1:0] memIdx[2];

  // Instance 0 is round-robin, instance 1 is fixed priority; only the selected one sees requests.
  for (genvar k = 0; k < 2; k++) begin : gInst
    logic [DB-1:0] mem [2**IB];
    logic [DB-1:0] dout;

    dmem_arbiter #(
      .DBITS       (DB),
      .DMEMADDRBITS(AB),
      .DMEMWORDBITS(WB),
      .FIXED_PRIO  (k),
      .STARVE_LIMIT(LIM)
    ) uDut (
      .clk        (clk),
      .reset      (reset),
      .r0_req     (r0Req && (sel == k)),
      .r0_we      (r0We),
      .r0_addr    (r0Addr),
      .r0_wdata   (r0Wdata),
      .r0_gnt     (r0Gnt[k]),
      .r0_rvalid  (r0Rv[k]),
      .r0_rdata   (r0Rd[k]),
      .r1_req     (r1Req && (sel == k)),
      .r1_we      (r1We),
      .r1_addr    (r1Addr),
      .r1_wdata   (r1Wdata),
      .r1_gnt     (r1Gnt[k]),
      .r1_rvalid  (r1Rv[k]),
      .r1_rdata   (r1Rd[k]),
      .mem_wrtEn  (memWe[k]),
      .mem_index  (memIdx[k]),
      .mem_dataIn (memDin[k]),
      .mem_dataOut(dout),
      .misalign   (misal[k])
    );

    always @(posedge clk) begin
      if (memClear) begin
        for (int i = 0; i < 2**IB; i++) mem[i] <= '0;
      end else begin
        if (memWe[k]) mem[memIdx[k]] <= memDin[k];
        dout <= mem[memIdx[k]];
      end
    end
  end

  // Reference model state
  int            vectors = 0;
  int            miscompares = 0;
  int            lastWin, starve, win;
  bit            pendV;
  int            pendOwn;
  logic [DB-1:0] pendData;
  logic [DB-1:0] expRd [2];
  logic [IB-1:0] expIdx;
  logic [DB-1:0] expDin;
  bit            expMis;
  logic [DB-1:0] refMem [2][2**IB];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s (mode %0d): observed %h expected %h", tag, sel, obs, exp);
    end
  endtask

  task automatic modelReset();
    lastWin  = 1;
    starve   = 0;
    pendV    = 0;
    pendOwn  = 0;
    pendData = '0;
    expRd[0] = '0;
    expRd[1] = '0;
    expIdx   = '0;
    expDin   = '0;
    expMis   = 0;
  endtask

  // Holds reset low for one clock with requests asserted; every output must read zero.
  task automatic applyReset();
    reset   = 1'b0;
    r0Req   = 1'b1; r0We = 1'b1; r0Addr = 13'h013; r0Wdata = 32'hA5A5A5A5;
    r1Req   = 1'b1; r1We = 1'b0; r1Addr = 13'h021; r1Wdata = 32'h5A5A5A5A;
    #1;
    checkOutput("rst_r0_gnt",    32'(r0Gnt[sel]),  32'd0);
    checkOutput("rst_r1_gnt",    32'(r1Gnt[sel]),  32'd0);
    checkOutput("rst_r0_rvalid", 32'(r0Rv[sel]),   32'd0);
    checkOutput("rst_r1_rvalid", 32'(r1Rv[sel]),   32'd0);
    checkOutput("rst_mem_wrtEn", 32'(memWe[sel]),  32'd0);
    checkOutput("rst_mem_index", 32'(memIdx[sel]), 32'd0);
    checkOutput("rst_mem_data",  memDin[sel],      32'd0);
    checkOutput("rst_r0_rdata",  r0Rd[sel],        32'd0);
    checkOutput("rst_r1_rdata",  r1Rd[sel],        32'd0);
    checkOutput("rst_misalign",  32'(misal[sel]),  32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    r0Req = 1'b0;
    r1Req = 1'b0;
    reset = 1'b1;
  endtask

  // One clock: drive requests, compare every output with the model, then advance the model past the edge.
  task automatic applyStimulus(input bit a0, input bit w0, input logic [AB-1:0] ad0, input logic [DB-1:0] d0,
                               input bit a1, input bit w1, input logic [AB-1:0] ad1, input logic [DB-1:0] d1);
    bit            gW;
    logic [AB-1:0] gA;
    logic [DB-1:0] gD;
    r0Req = a0; r0We = w0; r0Addr = ad0; r0Wdata = d0;
    r1Req = a1; r1We = w1; r1Addr = ad1; r1Wdata = d1;
    #1;
    if (a0 && a1) begin
      if (sel == 1) win = (starve >= LIM) ? 1 : 0;
      else          win = (lastWin == 0) ? 1 : 0;
    end else if (a0) win = 0;
    else if (a1)     win = 1;
    else             win = -1;
    gW = (win == 1) ? w1  : w0;
    gA = (win == 1) ? ad1 : ad0;
    gD = (win == 1) ? d1  : d0;
    if (win >= 0) begin
      expIdx = gA[AB-1:WB];
      expDin = gD;
    end
    if (pendV) expRd[pendOwn] = pendData;

    checkOutput("r0_gnt",     32'(r0Gnt[sel]),  32'(win == 0));
    checkOutput("r1_gnt",     32'(r1Gnt[sel]),  32'(win == 1));
    checkOutput("mem_wrtEn",  32'(memWe[sel]),  32'((win >= 0) && gW));
    checkOutput("mem_index",  32'(memIdx[sel]), 32'(expIdx));
    checkOutput("mem_dataIn", memDin[sel],      expDin);
    checkOutput("r0_rvalid",  32'(r0Rv[sel]),   32'(pendV && pendOwn == 0));
    checkOutput("r1_rvalid",  32'(r1Rv[sel]),   32'(pendV && pendOwn == 1));
    checkOutput("r0_rdata",   r0Rd[sel],        expRd[0]);
    checkOutput("r1_rdata",   r1Rd[sel],        expRd[1]);
    checkOutput("misalign",   32'(misal[sel]),  32'(expMis));

    pendV = 0;
    if (win >= 0) begin
      lastWin = win;
      if (gA[WB-1:0] != '0) expMis = 1;
      if (gW) begin
        refMem[sel][gA[AB-1:WB]] = gD;
      end else begin
        pendV    = 1;
        pendOwn  = win;
        pendData = refMem[sel][gA[AB-1:WB]];
      end
    end
    if (sel == 1) starve = (a1 && win != 1) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Random traffic: each requester holds its request until the model grants it, occasionally withdrawing early.
  task automatic runRandom(input int cycles);
    bit            act [2];
    bit            we  [2];
    logic [AB-1:0] ad  [2];
    logic [DB-1:0] wd  [2];
    logic [IB-1:0] ix;
    logic [WB-1:0] off;
    for (int j = 0; j < 2; j++) begin
      act[j] = 0; we[j] = 0; ad[j] = '0; wd[j] = '0;
    end
    for (int n = 0; n < cycles; n++) begin
      for (int j = 0; j < 2; j++) begin
        if (!act[j]) begin
          if ($urandom_range(0, 9) < 6) begin
            ix     = IB'($urandom_range(0, 15));
            off    = ($urandom_range(0, 15) == 0) ? WB'($urandom_range(1, 3)) : '0;
            act[j] = 1;
            we[j]  = 1'($urandom_range(0, 1));
            ad[j]  = {ix, off};
            wd[j]  = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          act[j] = 0;
        end
      end
      applyStimulus(act[0], we[0], ad[0], wd[0], act[1], we[1], ad[1], wd[1]);
      if (win >= 0) act[win] = 0;
    end
  endtask

  initial begin
    sel      = 0;
    memClear = 1'b1;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 2**IB; i++) refMem[m][i] = '0;
    applyReset();
    memClear = 1'b0;

    $display("[TB] round-robin: write then read back");
    applyStimulus(1, 1, 13'h010, 32'hDEADBEEF, 0, 0, '0, '0);
    applyStimulus(1, 0, 13'h010, '0,           0, 0, '0, '0);
    idleCycle();

    $display("[TB] round-robin: both reading continuously");
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 13'h010, '0, 1, 0, 13'h020, '0);
    idleCycle();

    $display("[TB] misaligned read is sticky");
    applyStimulus(0, 0, '0, '0, 1, 0, 13'h013, '0);
    applyStimulus(1, 1, 13'h020, 32'h0BADF00D, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 0, 13'h020, '0);
    idleCycle();

    $display("[TB] withdrawn request leaves no trace");
    applyReset();
    applyStimulus(1, 1, 13'h040, 32'h12345678, 1, 1, 13'h044, 32'hCAFEF00D);
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
    applyStimulus(1, 0, 13'h044, '0, 1, 0, 13'h040, '0);
    idleCycle();

    $display("[TB] reset during a pending read");
    applyStimulus(1, 0, 13'h040, '0, 0, 0, '0, '0);
    applyReset();
    idleCycle();
    idleCycle();

    runRandom(300);

    $display("[TB] fixed priority with starvation cap");
    sel = 1;
    applyReset();
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 13'h008, '0, 1, 0, 13'h00C, '0);
    idleCycle();
    runRandom(300);
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
